// File: rtl/ddram_cache_port.sv
// CPU/DMA client for the shared 64-bit DDRAM port: direct-mapped, write-through
// cache of 64-bit lines with per-byte valid masks and an explicit flush.
module ddram_cache_port #(
    parameter int         DW    = 8,
    parameter int         LINES = 4,
    parameter logic [3:0] BASE  = 4'b0011
) (
    input  logic          DDRAM_CLK,
    input  logic          reset_n,
    input  logic          DDRAM_BUSY,
    output logic [7:0]    DDRAM_BURSTCNT,
    output logic [28:0]   DDRAM_ADDR,
    input  logic [63:0]   DDRAM_DOUT,
    input  logic          DDRAM_DOUT_READY,
    output logic          DDRAM_RD,
    output logic [63:0]   DDRAM_DIN,
    output logic [7:0]    DDRAM_BE,
    output logic          DDRAM_WE,
    input  logic [27:0]   addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    input  logic          we,
    input  logic          rd,
    input  logic          flush,
    output logic          ready
);

    // state | meaning
    // IDLE  | strobe edges and flush accepted, read hits served
    // WR    | write-through request held on the DDR port
    // RD    | line read request held on the DDR port
    // FILL  | waiting for DDRAM_DOUT_READY
    typedef enum logic [1:0] {IDLE, WR, RD, FILL} state_t;

    localparam int            IW       = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int            BPL      = DW / 8;
    localparam logic [IW-1:0] IDX_MASK = IW'(LINES - 1);

    state_t         state_q, state_d;
    logic [7:0]     valid_q [LINES];
    logic [7:0]     valid_d [LINES];
    logic [24:0]    tag_q   [LINES];
    logic [24:0]    tag_d   [LINES];
    logic [63:0]    data_q  [LINES];
    logic [63:0]    data_d  [LINES];
    logic [DW-1:0]  dout_q, dout_d;
    logic           old_rd_q, old_rd_d;
    logic           old_we_q, old_we_d;
    logic           flush_pend_q, flush_pend_d;
    logic [24:0]    req_la_q, req_la_d;
    logic [2:0]     req_boff_q, req_boff_d;
    logic [28:0]    ddr_addr_q, ddr_addr_d;
    logic [63:0]    ddr_din_q, ddr_din_d;
    logic [7:0]     ddr_be_q, ddr_be_d;
    logic           ddr_rd_q, ddr_rd_d;
    logic           ddr_we_q, ddr_we_d;

    logic [24:0]    cpu_la;
    logic [IW-1:0]  cpu_idx;
    logic [IW-1:0]  req_idx;
    logic [2:0]     cpu_boff;
    logic [7:0]     cpu_lmask;
    logic [63:0]    din_rep;
    logic [63:0]    line_w;
    logic           hit;
    logic           rd_rise;
    logic           we_rise;

    // Tags keep the whole line address; the index bits always match by construction.
    assign cpu_la    = addr[27:3];
    assign cpu_idx   = cpu_la[IW-1:0] & IDX_MASK;
    assign req_idx   = req_la_q[IW-1:0] & IDX_MASK;
    assign cpu_boff  = addr[2:0] & ~3'(BPL - 1);
    assign cpu_lmask = 8'(((1 << BPL) - 1) << cpu_boff);
    assign din_rep   = {(64 / DW){din}};
    assign rd_rise   = rd & ~old_rd_q;
    assign we_rise   = we & ~old_we_q;
    assign hit       = (tag_q[cpu_idx] == cpu_la) &&
                       ((valid_q[cpu_idx] & cpu_lmask) == cpu_lmask);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        dout_d       = dout_q;
        old_rd_d     = old_rd_q;
        old_we_d     = old_we_q;
        flush_pend_d = flush_pend_q;
        req_la_d     = req_la_q;
        req_boff_d   = req_boff_q;
        ddr_addr_d   = ddr_addr_q;
        ddr_din_d    = ddr_din_q;
        ddr_be_d     = ddr_be_q;
        ddr_rd_d     = ddr_rd_q;
        ddr_we_d     = ddr_we_q;
        line_w       = data_q[cpu_idx];
        for (int b = 0; b < 8; b++) begin
            if (cpu_lmask[b]) line_w[b*8 +: 8] = din_rep[b*8 +: 8];
        end

        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    // old_rd/old_we untouched so an edge during flush still fires afterwards
                    for (int i = 0; i < LINES; i++) valid_d[i] = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    old_rd_d = rd;
                    old_we_d = we;
                    if (we_rise) begin
                        if (tag_q[cpu_idx] == cpu_la) begin
                            valid_d[cpu_idx] = valid_q[cpu_idx] | cpu_lmask;
                        end else begin
                            tag_d[cpu_idx]   = cpu_la;
                            valid_d[cpu_idx] = cpu_lmask;
                        end
                        data_d[cpu_idx] = line_w;
                        ddr_we_d        = 1'b1;
                        ddr_addr_d      = {BASE, cpu_la};
                        ddr_din_d       = din_rep;
                        ddr_be_d        = cpu_lmask;
                        // a read edge coinciding with the write is replayed after WR
                        if (rd_rise) old_rd_d = 1'b0;
                        state_d = WR;
                    end else if (rd_rise) begin
                        if (hit) begin
                            dout_d = DW'(data_q[cpu_idx] >> {cpu_boff, 3'b000});
                        end else begin
                            ddr_rd_d   = 1'b1;
                            ddr_addr_d = {BASE, cpu_la};
                            ddr_be_d   = 8'hFF;
                            req_la_d   = cpu_la;
                            req_boff_d = cpu_boff;
                            state_d    = RD;
                        end
                    end
                end
            end
            WR: begin
                if (!DDRAM_BUSY) begin
                    ddr_we_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD: begin
                if (!DDRAM_BUSY) begin
                    ddr_rd_d = 1'b0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (DDRAM_DOUT_READY) begin
                    data_d[req_idx]  = DDRAM_DOUT;
                    tag_d[req_idx]   = req_la_q;
                    valid_d[req_idx] = 8'hFF;
                    dout_d           = DW'(DDRAM_DOUT >> {req_boff_q, 3'b000});
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && flush) flush_pend_d = 1'b1;
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            valid_q      <= '{default: '0};
            dout_q       <= '0;
            old_rd_q     <= 1'b1;
            old_we_q     <= 1'b1;
            flush_pend_q <= 1'b0;
            ddr_be_q     <= '0;
            ddr_rd_q     <= 1'b0;
            ddr_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dout_q       <= dout_d;
            old_rd_q     <= old_rd_d;
            old_we_q     <= old_we_d;
            flush_pend_q <= flush_pend_d;
            ddr_be_q     <= ddr_be_d;
            ddr_rd_q     <= ddr_rd_d;
            ddr_we_q     <= ddr_we_d;
        end
    end

    always_ff @(posedge DDRAM_CLK) begin
        tag_q      <= tag_d;
        data_q     <= data_d;
        req_la_q   <= req_la_d;
        req_boff_q <= req_boff_d;
        ddr_addr_q <= ddr_addr_d;
        ddr_din_q  <= ddr_din_d;
    end

    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = ddr_addr_q;
    assign DDRAM_DIN      = ddr_din_q;
    assign DDRAM_BE       = ddr_be_q;
    assign DDRAM_RD       = ddr_rd_q;
    assign DDRAM_WE       = ddr_we_q;
    assign dout           = dout_q;
    assign ready          = (state_q == IDLE);

endmodule

// File: tb/tb_ddram_cache_port.sv
// Bench for ddram_cache_port: directed vector table, hand-written corner sequences,
// and a randomized run checked against a flat byte-memory reference.
module tb_ddram_cache_port;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // DW=8 instance
    logic        ddr_busy, ddr_rdy, ddr_rd, ddr_we;
    logic [7:0]  ddr_bc, ddr_be;
    logic [28:0] ddr_addr;
    logic [63:0] ddr_dout, ddr_din;
    logic [27:0] addr;
    logic [7:0]  din, dout;
    logic        we, rd, flush, ready;

    ddram_cache_port #(.DW(8), .LINES(4), .BASE(4'b0011)) dut (
        .DDRAM_CLK(clk), .reset_n(reset_n), .DDRAM_BUSY(ddr_busy), .DDRAM_BURSTCNT(ddr_bc),
        .DDRAM_ADDR(ddr_addr), .DDRAM_DOUT(ddr_dout), .DDRAM_DOUT_READY(ddr_rdy),
        .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din), .DDRAM_BE(ddr_be), .DDRAM_WE(ddr_we),
        .addr(addr), .din(din), .dout(dout), .we(we), .rd(rd), .flush(flush), .ready(ready)
    );

    // DW=16 instance, DDR side driven by hand
    logic        b16, rdy16, ddr16_rd, ddr16_we;
    logic [7:0]  ddr16_bc, ddr16_be;
    logic [28:0] ddr16_addr;
    logic [63:0] ddr16_dout, ddr16_din;
    logic [27:0] addr16;
    logic [15:0] din16, dout16;
    logic        we16, rd16, flush16, ready16;

    ddram_cache_port #(.DW(16), .LINES(4), .BASE(4'b0011)) dut16 (
        .DDRAM_CLK(clk), .reset_n(reset_n), .DDRAM_BUSY(b16), .DDRAM_BURSTCNT(ddr16_bc),
        .DDRAM_ADDR(ddr16_addr), .DDRAM_DOUT(ddr16_dout), .DDRAM_DOUT_READY(rdy16),
        .DDRAM_RD(ddr16_rd), .DDRAM_DIN(ddr16_din), .DDRAM_BE(ddr16_be), .DDRAM_WE(ddr16_we),
        .addr(addr16), .din(din16), .dout(dout16), .we(we16), .rd(rd16), .flush(flush16),
        .ready(ready16)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DDR memory responder (environment for the DW=8 instance)
    logic [63:0] mem [int unsigned];
    int          stall_cfg = 0, rd_lat = 2;
    bit          in_req = 0;
    int          stall_left = 0, ret_cnt = 0;
    int unsigned ret_la;
    int          rd_acc = 0, we_acc = 0, we_hi = 0, ret_done = 0, proto_err = 0;
    logic [28:0] last_addr;
    logic [7:0]  last_be;
    logic [63:0] last_din;

    function automatic logic [63:0] def_line(input int unsigned la);
        logic [63:0] l;
        for (int b = 0; b < 8; b++) l[b*8 +: 8] = 8'((la * 8 + b) ^ 8'hC3);
        return l;
    endfunction

    always @(negedge clk) begin
        logic [63:0] t;
        int unsigned la;
        ddr_rdy = 1'b0;
        if (ret_cnt > 0) begin
            ret_cnt--;
            if (ret_cnt == 0) begin
                ddr_dout = mem.exists(ret_la) ? mem[ret_la] : def_line(ret_la);
                ddr_rdy  = 1'b1;
                ret_done++;
            end
        end
        if (ddr_rd && ddr_we) proto_err++;
        if (ddr_rd && ddr_be != 8'hFF) proto_err++;
        if (ddr_we) we_hi++;
        if (ddr_rd || ddr_we) begin
            if (ddr_addr[28:25] != 4'b0011) proto_err++;
            if (!in_req) begin
                in_req = 1'b1;
                stall_left = stall_cfg;
            end
            if (stall_left > 0) begin
                ddr_busy = 1'b1;
                stall_left--;
            end else begin
                ddr_busy  = 1'b0;
                in_req    = 1'b0;
                la        = int'(ddr_addr[24:0]);
                last_addr = ddr_addr;
                last_be   = ddr_be;
                last_din  = ddr_din;
                if (ddr_we) begin
                    t = mem.exists(la) ? mem[la] : def_line(la);
                    for (int b = 0; b < 8; b++) if (ddr_be[b]) t[b*8 +: 8] = ddr_din[b*8 +: 8];
                    mem[la] = t;
                    we_acc++;
                end else begin
                    ret_la  = la;
                    ret_cnt = rd_lat;
                    rd_acc++;
                end
            end
        end else begin
            ddr_busy = 1'b0;
        end
    end

    task automatic cpu_read(input logic [27:0] a, output logic [7:0] d, output int nrd,
                            output bit dropped);
        int r0, n;
        tick();
        tick();
        r0 = rd_acc;
        dropped = 1'b0;
        n = 0;
        addr = a;
        rd = 1'b1;
        tick();
        while (!ready && n < 100) begin
            dropped = 1'b1;
            tick();
            n++;
        end
        chk("rd_done", ready, 1'b1);
        d = dout;
        nrd = rd_acc - r0;
        rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [27:0] a, input logic [7:0] d, output int wcyc,
                             output int nwe);
        int w0, a0, n;
        tick();
        tick();
        w0 = we_hi;
        a0 = we_acc;
        n = 0;
        addr = a;
        din = d;
        we = 1'b1;
        tick();
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk("wr_done", ready, 1'b1);
        wcyc = we_hi - w0;
        nwe = we_acc - a0;
        we = 1'b0;
    endtask

    task automatic flush_pulse();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [27:0] a;
        logic [7:0]  d;
        int          stall;
        int          exp_rds;
        logic [7:0]  exp_v;
        logic [7:0]  exp_be;
    } vec_t;

    vec_t        vecs[9];
    logic [7:0]  ref_bytes[256];

    initial begin
        logic [7:0]  got;
        logic [63:0] t;
        int          nrd, wcyc, nwe, r0, w0, n, ret0;
        bit          dropped, bad;

        // address, data, stall, expected DDR reads, expected data / lane, expected BE
        vecs[0] = '{0, 28'h10, 8'h00, 0, 1, 8'h11, 8'hFF};
        vecs[1] = '{0, 28'h13, 8'h00, 0, 0, 8'h44, 8'hFF};
        vecs[2] = '{1, 28'h25, 8'hA5, 3, 0, 8'hA5, 8'h20};
        vecs[3] = '{0, 28'h25, 8'h00, 0, 0, 8'hA5, 8'hFF};
        vecs[4] = '{1, 28'h2E, 8'h3C, 0, 0, 8'h3C, 8'h40};
        vecs[5] = '{0, 28'h2E, 8'h00, 0, 0, 8'h3C, 8'hFF};
        vecs[6] = '{0, 28'h00, 8'h00, 0, 1, 8'hC3, 8'hFF};
        vecs[7] = '{0, 28'h20, 8'h00, 1, 1, 8'hE3, 8'hFF};
        vecs[8] = '{0, 28'h00, 8'h00, 2, 1, 8'hC3, 8'hFF};

        ddr_busy = 0; ddr_rdy = 0; ddr_dout = '0;
        addr = '0; din = '0; we = 0; rd = 1; flush = 0;
        b16 = 0; rdy16 = 0; ddr16_dout = '0;
        addr16 = '0; din16 = '0; we16 = 0; rd16 = 0; flush16 = 0;
        mem[2] = 64'h8877665544332211;

        // reset with rd held high: the held strobe must not fire afterwards
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_dout", dout, 8'h00);
        chk("rst_ddr_rd", ddr_rd, 1'b0);
        chk("rst_ddr_we", ddr_we, 1'b0);
        chk("rst_burstcnt", ddr_bc, 8'd1);
        tick();
        tick();
        chk("rst_held_rd_no_req", rd_acc, 0);
        chk("rst_held_rd_no_fire", ddr_rd, 1'b0);
        rd = 0;

        for (int i = 0; i < 9; i++) begin
            stall_cfg = vecs[i].stall;
            if (vecs[i].wr) begin
                cpu_write(vecs[i].a, vecs[i].d, wcyc, nwe);
                chk("vec_we_cycles", wcyc, vecs[i].stall + 1);
                chk("vec_we_count", nwe, 1);
                chk("vec_wr_be", last_be, vecs[i].exp_be);
                t = last_din >> (vecs[i].a[2:0] * 8);
                chk("vec_wr_din_lane", t[7:0], vecs[i].exp_v);
                chk("vec_wr_addr", last_addr, {4'b0011, vecs[i].a[27:3]});
            end else begin
                cpu_read(vecs[i].a, got, nrd, dropped);
                chk("vec_rd_data", got, vecs[i].exp_v);
                chk("vec_rd_count", nrd, vecs[i].exp_rds);
                if (vecs[i].exp_rds == 0) begin
                    chk("vec_hit_ready_kept", dropped, 1'b0);
                end else begin
                    chk("vec_rd_addr", last_addr, {4'b0011, vecs[i].a[27:3]});
                    chk("vec_rd_be", last_be, 8'hFF);
                end
            end
        end
        stall_cfg = 0;

        // flush in IDLE invalidates the line cached by the first read
        flush_pulse();
        cpu_read(28'h13, got, nrd, dropped);
        chk("flush_miss_count", nrd, 1);
        chk("flush_miss_data", got, 8'h44);

        // DW=16: lane from DOUT[63:48], addr[0] ignored on writes
        tick();
        addr16 = 28'h16;
        rd16 = 1;
        n = 0;
        tick();
        while (!ddr16_rd && n < 20) begin
            tick();
            n++;
        end
        chk("w16_rd_req", ddr16_rd, 1'b1);
        chk("w16_rd_addr", ddr16_addr, 29'h0600_0002);
        chk("w16_rd_be", ddr16_be, 8'hFF);
        tick();
        ddr16_dout = 64'h8877665544332211;
        rdy16 = 1;
        tick();
        rdy16 = 0;
        chk("w16_fill_dout", dout16, 16'h8877);
        chk("w16_fill_ready", ready16, 1'b1);
        rd16 = 0;
        tick();
        tick();
        addr16 = 28'h17;
        din16 = 16'hBEEF;
        we16 = 1;
        tick();
        chk("w16_we", ddr16_we, 1'b1);
        chk("w16_be", ddr16_be, 8'hC0);
        chk("w16_din_lane", ddr16_din[63:48], 16'hBEEF);
        tick();
        chk("w16_we_released", ddr16_we, 1'b0);
        we16 = 0;
        tick();
        tick();
        addr16 = 28'h16;
        rd16 = 1;
        tick();
        chk("w16_hit_dout", dout16, 16'hBEEF);
        chk("w16_hit_no_rd", ddr16_rd, 1'b0);
        chk("w16_hit_ready", ready16, 1'b1);
        rd16 = 0;

        // flush arriving during FILL is applied once back in IDLE
        rd_lat = 5;
        tick();
        tick();
        addr = 28'h58;
        rd = 1;
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0;
        n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk("dflush_fill_done", ready, 1'b1);
        chk("dflush_fill_data", dout, 8'h9B);
        rd = 0;
        rd_lat = 2;
        cpu_read(28'h58, got, nrd, dropped);
        chk("dflush_miss_count", nrd, 1);
        chk("dflush_miss_data", got, 8'h9B);

        // write and read edges together: write goes out first, then the read is served
        stall_cfg = 1;
        tick();
        tick();
        w0 = we_acc;
        r0 = rd_acc;
        addr = 28'h31;
        din = 8'h77;
        we = 1;
        rd = 1;
        tick();
        chk("sim_wr_not_rd", ddr_rd, 1'b0);
        n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk("sim_wr_count", we_acc - w0, 1);
        we = 0;
        tick();
        chk("sim_rd_after_wr", dout, 8'h77);
        chk("sim_rd_ready", ready, 1'b1);
        chk("sim_rd_no_ddr", rd_acc - r0, 0);
        rd = 0;
        stall_cfg = 0;

        // reset during FILL: abort, late DOUT_READY ignored
        rd_lat = 20;
        tick();
        tick();
        r0 = rd_acc;
        addr = 28'h88;
        rd = 1;
        tick();
        n = 0;
        while (rd_acc == r0 && n < 20) begin
            tick();
            n++;
        end
        chk("rstf_rd_issued", rd_acc - r0, 1);
        tick();
        chk("rstf_busy", ready, 1'b0);
        ret0 = ret_done;
        reset_n = 0;
        tick();
        reset_n = 1;
        chk("rstf_ready", ready, 1'b1);
        chk("rstf_ddr_rd", ddr_rd, 1'b0);
        chk("rstf_dout", dout, 8'h00);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (!ready || dout !== 8'h00) bad = 1;
        end
        chk("rstf_late_ignored", bad, 1'b0);
        chk("rstf_late_delivered", ret_done - ret0, 1);
        chk("rstf_no_new_rd", rd_acc - r0, 1);
        rd = 0;
        rd_lat = 2;
        cpu_read(28'h88, got, nrd, dropped);
        chk("rstf_reread_count", nrd, 1);
        chk("rstf_reread_data", got, 8'h4B);

        // randomized traffic against a flat byte memory
        reset_n = 0;
        tick();
        reset_n = 1;
        mem.delete();
        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'($urandom);
        for (int la = 0; la < 32; la++) begin
            for (int b = 0; b < 8; b++) t[b*8 +: 8] = ref_bytes[la*8 + b];
            mem[la] = t;
        end
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [27:0] a;
            logic [7:0]  d;
            op = $urandom_range(0, 99);
            a = 28'($urandom_range(0, 255));
            d = 8'($urandom);
            stall_cfg = $urandom_range(0, 2);
            rd_lat = $urandom_range(1, 4);
            if (op < 10) begin
                flush_pulse();
            end else if (op < 50) begin
                cpu_write(a, d, wcyc, nwe);
                chk("rand_we_count", nwe, 1);
                ref_bytes[a[7:0]] = d;
            end else begin
                cpu_read(a, got, nrd, dropped);
                chk("rand_rd_data", got, ref_bytes[a[7:0]]);
            end
        end
        tick();
        for (int la = 0; la < 32; la++) begin
            for (int b = 0; b < 8; b++) t[b*8 +: 8] = ref_bytes[la*8 + b];
            chk("rand_mem_line", mem[la], t);
        end
        chk("protocol_errors", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1);
    end

endmodule
